// File: rtl/id_scoreboard_pkg.sv
// Shared defines for the decode-stage operand/hazard logic.
package id_scoreboard_pkg;

  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 5;

  localparam logic [XLEN_DEF-1:0] Zero_Word    = 32'h0000_0000;
  localparam logic [AW_DEF-1:0]   Null_RegAddr = 5'd0;
  localparam logic                Enabled      = 1'b1;
  localparam logic                Disabled     = 1'b0;

endpackage

// File: rtl/id_scoreboard_if.sv
// Decoder/pipeline-side bundle of the operand-resolution and hazard unit.
interface id_scoreboard_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2,
  parameter int NFWD = 2
);

  logic                 issue_i;
  logic [NRD-1:0]       rs_read_i;
  logic [NRD*AW-1:0]    rs_addr_i;
  logic [NRD*XLEN-1:0]  rf_data_i;
  logic                 rd_wreg_i;
  logic [AW-1:0]        rd_addr_i;
  logic [NFWD-1:0]      fwd_valid_i;
  logic [NFWD-1:0]      fwd_ready_i;
  logic [NFWD*AW-1:0]   fwd_addr_i;
  logic [NFWD*XLEN-1:0] fwd_data_i;
  logic                 wb_valid_i;
  logic [AW-1:0]        wb_addr_i;
  logic [XLEN-1:0]      wb_data_i;
  logic [NRD*XLEN-1:0]  opnd_o;
  logic                 stallreq_o;
  logic                 issue_fire_o;
  logic [NREG-1:0]      busy_o;
  logic                 err_o;

  modport master (
    output issue_i, rs_read_i, rs_addr_i, rf_data_i, rd_wreg_i, rd_addr_i,
           fwd_valid_i, fwd_ready_i, fwd_addr_i, fwd_data_i,
           wb_valid_i, wb_addr_i, wb_data_i,
    input  opnd_o, stallreq_o, issue_fire_o, busy_o, err_o
  );

  modport slave (
    input  issue_i, rs_read_i, rs_addr_i, rf_data_i, rd_wreg_i, rd_addr_i,
           fwd_valid_i, fwd_ready_i, fwd_addr_i, fwd_data_i,
           wb_valid_i, wb_addr_i, wb_data_i,
    output opnd_o, stallreq_o, issue_fire_o, busy_o, err_o
  );

endinterface

// File: rtl/id_opnd_resolve.sv
// Single source-operand priority mux: zero reg, youngest bypass, writeback, then
// register file; flags a stall when the value is not yet available.
module id_opnd_resolve
  import id_scoreboard_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF,
  parameter int NFWD = 2
) (
  input  logic                 rs_read,
  input  logic [AW-1:0]        rs_addr,
  input  logic [XLEN-1:0]      rf_data,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD-1:0]      fwd_ready,
  input  logic [NFWD*AW-1:0]   fwd_addr,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic                 wb_valid,
  input  logic [AW-1:0]        wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 reg_busy,
  output logic [XLEN-1:0]      opnd,
  output logic                 stall
);

  logic            hit_s;
  logic [XLEN-1:0] opnd_s;
  logic            stall_s;

  // First matching source wins; a non-ready youngest match blocks older sources.
  always_comb begin
    hit_s   = Disabled;
    opnd_s  = {XLEN{1'b0}};
    stall_s = Disabled;
    if (!rs_read || (rs_addr == {AW{1'b0}})) begin
      hit_s = Enabled;
    end else begin
      for (int j = 0; j < NFWD; j++) begin
        if (!hit_s && fwd_valid[j] && (fwd_addr[j*AW +: AW] == rs_addr)) begin
          hit_s = Enabled;
          if (fwd_ready[j]) begin
            opnd_s = fwd_data[j*XLEN +: XLEN];
          end else begin
            stall_s = Enabled;
          end
        end else begin
          hit_s = hit_s;
        end
      end
      if (hit_s) begin
        stall_s = stall_s;
      end else if (wb_valid && (wb_addr == rs_addr)) begin
        opnd_s = wb_data;
      end else if (reg_busy) begin
        stall_s = Enabled;
      end else begin
        opnd_s = rf_data;
      end
    end
  end

  assign opnd  = opnd_s;
  assign stall = stall_s;

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage scoreboard: per-register pending-write counters, operand
// resolution for NRD ports and the resulting issue stall.
module id_scoreboard
  import id_scoreboard_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREG  = 32,
  parameter int AW    = AW_DEF,
  parameter int NRD   = 2,
  parameter int NFWD  = 2,
  parameter int CNT_W = 2
) (
  input logic            clk,
  input logic            rst,
  id_scoreboard_if.slave sb
);

  logic [CNT_W-1:0] pending_r [NREG];
  logic             err_r;
  logic [NREG-1:0]  busy_s;
  logic [NREG-1:0]  inc_s;
  logic [NREG-1:0]  dec_s;
  logic [XLEN-1:0]  opnd_s [NRD];
  logic [NRD-1:0]   port_stall_s;
  logic             sat_s;
  logic             stall_s;
  logic             fire_s;

  // Busy map and per-register increment/decrement requests.
  always_comb begin
    busy_s = {NREG{1'b0}};
    inc_s  = {NREG{1'b0}};
    dec_s  = {NREG{1'b0}};
    for (int r = 1; r < NREG; r++) begin
      busy_s[r] = (pending_r[r] != {CNT_W{1'b0}});
      inc_s[r]  = fire_s && sb.rd_wreg_i && (sb.rd_addr_i == AW'(r));
      dec_s[r]  = sb.wb_valid_i && (sb.wb_addr_i == AW'(r));
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_port
    id_opnd_resolve #(.XLEN(XLEN), .AW(AW), .NFWD(NFWD)) u_resolve (
      .rs_read   (sb.rs_read_i[k]),
      .rs_addr   (sb.rs_addr_i[k*AW +: AW]),
      .rf_data   (sb.rf_data_i[k*XLEN +: XLEN]),
      .fwd_valid (sb.fwd_valid_i),
      .fwd_ready (sb.fwd_ready_i),
      .fwd_addr  (sb.fwd_addr_i),
      .fwd_data  (sb.fwd_data_i),
      .wb_valid  (sb.wb_valid_i),
      .wb_addr   (sb.wb_addr_i),
      .wb_data   (sb.wb_data_i),
      .reg_busy  (busy_s[sb.rs_addr_i[k*AW +: AW]]),
      .opnd      (opnd_s[k]),
      .stall     (port_stall_s[k])
    );
  end

  // Saturated destination counter blocks issue; the stall gates the increment.
  always_comb begin
    sat_s   = sb.rd_wreg_i && (sb.rd_addr_i != {AW{1'b0}}) &&
              (pending_r[sb.rd_addr_i] == {CNT_W{1'b1}});
    stall_s = sb.issue_i && ((|port_stall_s) || sat_s);
    fire_s  = sb.issue_i && !stall_s;
  end

  // Flatten per-port operands onto the bus.
  always_comb begin
    sb.opnd_o = {NRD*XLEN{1'b0}};
    for (int k = 0; k < NRD; k++) begin
      sb.opnd_o[k*XLEN +: XLEN] = opnd_s[k];
    end
  end

  assign sb.stallreq_o   = stall_s;
  assign sb.issue_fire_o = fire_s;
  assign sb.busy_o       = busy_s;
  assign sb.err_o        = err_r;

  // Pending counters and sticky underflow error; simultaneous inc/dec cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        pending_r[r] <= {CNT_W{1'b0}};
      end
      err_r <= Disabled;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (r == 0) begin
          pending_r[r] <= {CNT_W{1'b0}};
        end else if (inc_s[r] && !dec_s[r]) begin
          pending_r[r] <= pending_r[r] + CNT_W'(1);
        end else if (dec_s[r] && !inc_s[r] && busy_s[r]) begin
          pending_r[r] <= pending_r[r] - CNT_W'(1);
        end else begin
          pending_r[r] <= pending_r[r];
        end
      end
      err_r <= err_r | (|(dec_s & ~inc_s & ~busy_s));
    end
  end

endmodule
